// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide unit.
// The pipeline side drives the master modport; the arithmetic unit takes the slave modport.
interface muldiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
);
    logic             start_i;
    logic             flush_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [REG_W-1:0] rd_i;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;
    logic [WIDTH-1:0] result_o;
    logic [REG_W-1:0] rd_o;

    modport master (
        output start_i, flush_i, op_i, a_i, b_i, rd_i,
        input  busy_o, done_o, stall_o, result_o, rd_o
    );

    modport slave (
        input  start_i, flush_i, op_i, a_i, b_i, rd_i,
        output busy_o, done_o, stall_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one product or quotient bit per cycle on unsigned
// magnitudes, with the sign applied in the last iteration and a one-cycle done strobe.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg, op_next;
    logic [REG_W-1:0]   rd_reg, rd_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               neg_reg, neg_next;
    logic [WIDTH-1:0]   result_reg, result_next;

    // Operand decode for the instruction waiting in Execute
    logic             a_signed, b_signed, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             in_is_div, in_is_rem, div_by_zero, div_ovf, fast_case;
    logic [WIDTH-1:0] fast_result;
    logic             accept;

    always_comb begin
        a_signed    = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                      (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
        b_signed    = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
        neg_a       = a_signed && bus.a_i[WIDTH-1];
        neg_b       = b_signed && bus.b_i[WIDTH-1];
        mag_a       = neg_a ? -bus.a_i : bus.a_i;
        mag_b       = neg_b ? -bus.b_i : bus.b_i;
        in_is_div   = bus.op_i[2];
        in_is_rem   = bus.op_i[1];
        div_by_zero = in_is_div && (bus.b_i == '0);
        div_ovf     = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                      (bus.a_i == MIN_VAL) && (bus.b_i == '1);
        fast_case   = div_by_zero || div_ovf;
        if (div_by_zero) begin
            fast_result = in_is_rem ? bus.a_i : '1;
        end else begin
            fast_result = in_is_rem ? '0 : MIN_VAL;
        end
        accept = bus.start_i && !bus.flush_i;
    end

    // Shift-add multiply step: multiplier sits in the low half and is consumed LSB first
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_next;

    always_comb begin
        mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                       (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end

    // Restoring divide step: remainder in the high half, dividend shifts out of the low half
    // while quotient bits shift in behind it
    logic [WIDTH:0]     div_upper;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_acc_next;

    always_comb begin
        div_upper = acc_reg[2*WIDTH-1:WIDTH-1];
        div_fits  = div_upper >= {1'b0, opnd_reg};
        div_rem   = div_upper[WIDTH-1:0] - opnd_reg;
        if (div_fits) begin
            div_acc_next = {div_rem, acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_next = {acc_reg[2*WIDTH-2:0], 1'b0};
        end
    end

    logic               run_is_div;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   div_val;
    logic [WIDTH-1:0]   final_result;

    always_comb begin
        run_is_div = op_reg[2];
        step_acc   = run_is_div ? div_acc_next : mul_acc_next;
        mul_prod   = neg_reg ? -mul_acc_next : mul_acc_next;
        div_val    = op_reg[1] ? div_acc_next[2*WIDTH-1:WIDTH] : div_acc_next[WIDTH-1:0];
        if (run_is_div) begin
            final_result = neg_reg ? -div_val : div_val;
        end else if (op_reg == OP_MUL) begin
            final_result = mul_prod[WIDTH-1:0];
        end else begin
            final_result = mul_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            rd_reg     <= '0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            rd_reg     <= rd_next;
            opnd_reg   <= opnd_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        rd_next     = rd_reg;
        opnd_next   = opnd_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next  = bus.op_i;
                    rd_next  = bus.rd_i;
                    neg_next = (in_is_div && in_is_rem) ? neg_a : (neg_a ^ neg_b);
                    // Divisor / multiplicand stays put; the other magnitude is iterated
                    if (in_is_div) begin
                        opnd_next = mag_b;
                        acc_next  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_next = mag_a;
                        acc_next  = {{WIDTH{1'b0}}, mag_b};
                    end
                    if (fast_case) begin
                        result_next = fast_result;
                        state_next  = DONE;
                    end else begin
                        cnt_next   = CNT_W'(WIDTH - 1);
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    state_next = IDLE;
                end else begin
                    acc_next = step_acc;
                    if (cnt_reg == '0) begin
                        result_next = final_result;
                        state_next  = DONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall only covers the accept edge and the iterations, so the done cycle advances the pipe
    always_comb begin
        bus.busy_o   = (state_reg == RUN);
        bus.done_o   = (state_reg == DONE);
        bus.result_o = result_reg;
        bus.rd_o     = rd_reg;
        bus.stall_o  = rst && (((state_reg == IDLE) && accept) || (state_reg == RUN));
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic RV32M reference model.
module tb_muldiv_unit;
    localparam int WIDTH = 32;
    localparam int REG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(WIDTH), .REG_W(REG_W)) bus ();
    muldiv_unit #(.WIDTH(WIDTH), .REG_W(REG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = '0;
        case (op)
            3'd0: begin r = ua * ub; return r[31:0]; end
            3'd1: begin r = sa * sb; return r[63:32]; end
            3'd2: begin r = sa * ub; return r[63:32]; end
            3'd3: begin r = ua * ub; return r[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; r = sa / sb; return r[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; r = ua / ub; return r[31:0]; end
            3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
            default: begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
        endcase
    endfunction

    // Called at posedge+1 with the unit in IDLE; returns in the done cycle with start still high
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        logic [31:0] expv;
        bit fast;
        int cycles;
        int busy_cycles;
        bit overlap;
        expv = model(op, a, b);
        fast = op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) &&
                                      a == 32'h80000000 && b == 32'hFFFFFFFF));
        bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.rd_i = rd;
        bus.flush_i = 1'b0; bus.start_i = 1'b1;
        #1;
        total_cnt++;
        if (bus.stall_o !== 1'b1) $display("FAIL stall_on_request got=%b want=1", bus.stall_o);
        else pass_cnt++;
        cycles = 0; busy_cycles = 0; overlap = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            if (bus.busy_o === 1'b1) busy_cycles++;
            if (bus.busy_o === 1'b1 && bus.done_o === 1'b1) overlap = 1;
        end while (bus.done_o !== 1'b1 && cycles < 100);
        total_cnt++;
        if (bus.done_o !== 1'b1) $display("FAIL done_timeout got=%b want=1", bus.done_o);
        else pass_cnt++;
        total_cnt++;
        if (cycles != (fast ? 1 : WIDTH + 1))
            $display("FAIL latency op=%0d got=%0d want=%0d", op, cycles, fast ? 1 : WIDTH + 1);
        else pass_cnt++;
        total_cnt++;
        if (busy_cycles != (fast ? 0 : WIDTH))
            $display("FAIL busy_cycles op=%0d got=%0d want=%0d", op, busy_cycles, fast ? 0 : WIDTH);
        else pass_cnt++;
        total_cnt++;
        if (overlap) $display("FAIL busy_done_overlap got=1 want=0");
        else pass_cnt++;
        total_cnt++;
        if (bus.result_o !== expv)
            $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", op, a, b, bus.result_o, expv);
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_o !== rd) $display("FAIL rd got=%0d want=%0d", bus.rd_o, rd);
        else pass_cnt++;
        total_cnt++;
        if (bus.stall_o !== 1'b0) $display("FAIL stall_in_done got=%b want=0", bus.stall_o);
        else pass_cnt++;
        $display("op=%0d a=%h b=%h rd=%0d result=%h expected=%h latency=%0d",
                 op, a, b, rd, bus.result_o, expv, cycles);
    endtask

    task automatic finish_op();
        bus.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start_i = 1'b1; bus.flush_i = 1'b0; bus.op_i = 3'd0;
        bus.a_i = 32'd3; bus.b_i = 32'd4; bus.rd_i = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy_o); else pass_cnt++;
        total_cnt++;
        if (bus.done_o !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done_o); else pass_cnt++;
        total_cnt++;
        if (bus.result_o !== 32'd0) $display("FAIL reset_result got=%h want=0", bus.result_o); else pass_cnt++;
        total_cnt++;
        if (bus.rd_o !== 5'd0) $display("FAIL reset_rd got=%0d want=0", bus.rd_o); else pass_cnt++;
        total_cnt++;
        if (bus.stall_o !== 1'b0) $display("FAIL reset_stall got=%b want=0", bus.stall_o); else pass_cnt++;
        $display("reset: busy=%b done=%b stall=%b", bus.busy_o, bus.done_o, bus.stall_o);
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6,
                                  3'd3, 3'd1, 3'd2, 3'd7, 3'd5};
        logic [31:0] as  [12] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5,
                                  32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd100, 32'd100};
        logic [31:0] bs  [12] = '{32'd6, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                  32'd7, 32'd7};
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 3));
            finish_op();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 15));
            do_op(op, a, b, 5'($urandom_range(0, 31)));
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        do_op(3'd1, $urandom, $urandom, 5'd11);
        bus.op_i = 3'd6; bus.a_i = $urandom; bus.b_i = 32'd13; bus.rd_i = 5'd12;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0)
            $display("FAIL b2b_start_in_done busy=%b done=%b want=0,0", bus.busy_o, bus.done_o);
        else pass_cnt++;
        do_op(3'd6, bus.a_i, 32'd13, 5'd12);
        finish_op();
    endtask

    task automatic test_flush();
        bit seen;
        bus.op_i = 3'd0; bus.a_i = 32'd7; bus.b_i = 32'd6; bus.rd_i = 5'd4;
        bus.flush_i = 1'b0; bus.start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy_o !== 1'b1) $display("FAIL flush_busy_before got=%b want=1", bus.busy_o); else pass_cnt++;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.busy_o !== 1'b0) $display("FAIL flush_busy_after got=%b want=0", bus.busy_o); else pass_cnt++;
        total_cnt++;
        if (bus.stall_o !== 1'b0) $display("FAIL flush_stall_idle got=%b want=0", bus.stall_o); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.busy_o !== 1'b0) $display("FAIL flush_start_accepted got=%b want=0", bus.busy_o); else pass_cnt++;
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o === 1'b1) seen = 1;
        end
        total_cnt++;
        if (seen) $display("FAIL flush_no_done got=1 want=0"); else pass_cnt++;
        $display("flush at E10: busy=%b done_seen=%0d", bus.busy_o, seen);
    endtask

    task automatic test_reset_abort();
        bit seen;
        bus.op_i = 3'd0; bus.a_i = 32'd9; bus.b_i = 32'd9; bus.rd_i = 5'd21;
        bus.flush_i = 1'b0; bus.start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy_o !== 1'b1) $display("FAIL rstab_busy_before got=%b want=1", bus.busy_o); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.stall_o !== 1'b0 ||
            bus.result_o !== 32'd0 || bus.rd_o !== 5'd0)
            $display("FAIL rstab_outputs busy=%b done=%b stall=%b result=%h rd=%0d want=all 0",
                     bus.busy_o, bus.done_o, bus.stall_o, bus.result_o, bus.rd_o);
        else pass_cnt++;
        bus.start_i = 1'b0;
        #2;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o === 1'b1) seen = 1;
        end
        total_cnt++;
        if (seen) $display("FAIL rstab_no_done got=1 want=0"); else pass_cnt++;
        $display("reset abort at E10: done_seen=%0d", seen);
        do_op(3'd0, 32'd7, 32'd6, 5'd5);
        finish_op();
    endtask

    initial begin
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0;
        bus.a_i = '0; bus.b_i = '0; bus.rd_i = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
